// File: rtl/taxi_eth_tx_tag_track.sv
// Tag tracker in front of the MAC TX path: stamps each outgoing frame with a free
// hardware tag, remembers the requester ID per tag, and maps MAC completions back.
module taxi_eth_tx_tag_track #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int USER_W  = 1,
    parameter int REQ_W   = 8,
    parameter int TX_ID_W = 8,
    parameter int TAG_W   = 4,
    parameter int TS_W    = 96
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_W-1:0]     s_axis_tx_tdata_i,
    input  logic [KEEP_W-1:0]     s_axis_tx_tkeep_i,
    input  logic                  s_axis_tx_tvalid_i,
    output logic                  s_axis_tx_tready_o,
    input  logic                  s_axis_tx_tlast_i,
    input  logic [REQ_W-1:0]      s_axis_tx_tid_i,
    input  logic [USER_W-1:0]     s_axis_tx_tuser_i,

    output logic [DATA_W-1:0]     m_axis_tx_tdata_o,
    output logic [KEEP_W-1:0]     m_axis_tx_tkeep_o,
    output logic                  m_axis_tx_tvalid_o,
    input  logic                  m_axis_tx_tready_i,
    output logic                  m_axis_tx_tlast_o,
    output logic [TX_ID_W-1:0]    m_axis_tx_tid_o,
    output logic [USER_W-1:0]     m_axis_tx_tuser_o,

    input  logic [TS_W-1:0]       s_axis_cpl_tdata_i,
    input  logic                  s_axis_cpl_tvalid_i,
    output logic                  s_axis_cpl_tready_o,
    input  logic [TAG_W-1:0]      s_axis_cpl_tid_i,

    output logic [TS_W-1:0]       m_axis_cpl_tdata_o,
    output logic [(TS_W+7)/8-1:0] m_axis_cpl_tkeep_o,
    output logic                  m_axis_cpl_tvalid_o,
    input  logic                  m_axis_cpl_tready_i,
    output logic                  m_axis_cpl_tlast_o,
    output logic [REQ_W-1:0]      m_axis_cpl_tid_o,

    output logic [TAG_W:0]        stat_inflight,
    output logic                  stat_err_unk_tag,
    output logic                  stat_alloc_stall
);

    localparam int TAG_N = 2 ** TAG_W;

    logic [TAG_N-1:0] free_q, free_d;
    logic [TAG_W:0]   inflight_q, inflight_d;
    logic             active_q, active_d;
    logic [TAG_W-1:0] cur_tag_q;
    logic             cpl_vld_q;
    logic [TS_W-1:0]  cpl_data_q;
    logic [REQ_W-1:0] cpl_id_q;
    logic             err_q;
    logic [REQ_W-1:0] id_table [TAG_N];

    logic [TAG_W-1:0] sel_tag;
    logic             tx_block, tx_hs, alloc;
    logic             cpl_rdy, cpl_hs, cpl_hit, cpl_unk;

    // Lowest-index free tag from the registered bitmap only
    always_comb begin
        sel_tag = '0;
        for (int i = TAG_N - 1; i >= 0; i--) begin
            if (free_q[i]) sel_tag = TAG_W'(i);
        end
    end

    assign tx_block = !active_q && !(|free_q);
    assign tx_hs    = s_axis_tx_tvalid_i && s_axis_tx_tready_o;
    assign alloc    = tx_hs && !active_q;
    assign active_d = tx_hs ? !s_axis_tx_tlast_i : active_q;

    assign s_axis_tx_tready_o = m_axis_tx_tready_i && !tx_block;
    assign m_axis_tx_tvalid_o = s_axis_tx_tvalid_i && !tx_block;
    assign m_axis_tx_tdata_o  = s_axis_tx_tdata_i;
    assign m_axis_tx_tkeep_o  = s_axis_tx_tkeep_i;
    assign m_axis_tx_tlast_o  = s_axis_tx_tlast_i;
    assign m_axis_tx_tuser_o  = s_axis_tx_tuser_i;
    assign m_axis_tx_tid_o    = TX_ID_W'(active_q ? cur_tag_q : sel_tag);
    assign stat_alloc_stall   = s_axis_tx_tvalid_i && tx_block;

    assign cpl_rdy = !cpl_vld_q || m_axis_cpl_tready_i;
    assign cpl_hs  = s_axis_cpl_tvalid_i && cpl_rdy;
    assign cpl_hit = cpl_hs && !free_q[s_axis_cpl_tid_i];
    assign cpl_unk = cpl_hs && free_q[s_axis_cpl_tid_i];

    // Allocation and free never target the same tag, so both apply in one cycle
    always_comb begin
        free_d = free_q;
        if (alloc)   free_d[sel_tag] = 1'b0;
        if (cpl_hit) free_d[s_axis_cpl_tid_i] = 1'b1;
        inflight_d = inflight_q;
        if (alloc && !cpl_hit)      inflight_d = inflight_q + 1'b1;
        else if (!alloc && cpl_hit) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q     <= '1;
            inflight_q <= '0;
            active_q   <= 1'b0;
            cur_tag_q  <= '0;
            cpl_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            free_q     <= free_d;
            inflight_q <= inflight_d;
            active_q   <= active_d;
            err_q      <= cpl_unk;
            if (alloc)   cur_tag_q <= sel_tag;
            if (cpl_rdy) cpl_vld_q <= cpl_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) id_table[sel_tag] <= s_axis_tx_tid_i;
        if (cpl_hit) begin
            cpl_data_q <= s_axis_cpl_tdata_i;
            cpl_id_q   <= id_table[s_axis_cpl_tid_i];
        end
    end

    assign s_axis_cpl_tready_o = cpl_rdy;
    assign m_axis_cpl_tvalid_o = cpl_vld_q;
    assign m_axis_cpl_tdata_o  = cpl_data_q;
    assign m_axis_cpl_tid_o    = cpl_id_q;
    assign m_axis_cpl_tlast_o  = 1'b1;
    assign m_axis_cpl_tkeep_o  = '1;
    assign stat_inflight       = inflight_q;
    assign stat_err_unk_tag    = err_q;

endmodule

// File: doc/taxi_eth_tx_tag_track.md
Name: taxi_eth_tx_tag_track

Overview:
- Tag tracker placed directly upstream of the 10G MAC-with-FIFOs TX path, in the logic clock domain.
- Allocates a free hardware tag to each outgoing frame and drives it on the frame's tid. Stores the requester's ID per tag.
- Consumes the MAC's TX completion stream (tag + PTP timestamp), frees the tag, and returns the completion carrying the original requester ID.
- Gives host logic arbitrary-width request IDs while the MAC completion path stays narrow and bounded.

Parameters:
TAG_W, 4, tag width; 2**TAG_W tags can be in flight at once.

Ports:
clk  input  1  logic clock.
rst  input  1  reset; asynchronous, active-high.
s_axis_tx  taxi_axis_if.snk  -  frames from host. tid = request ID (REQ_W = s_axis_tx.ID_W). tuser = bad-frame flag.
m_axis_tx  taxi_axis_if.src  -  frames to the MAC FIFO. tid = allocated tag; m_axis_tx.ID_W >= TAG_W, upper bits zero.
s_axis_cpl  taxi_axis_if.snk  -  MAC TX completions. tid[TAG_W-1:0] = tag. tdata = PTP timestamp (TS_W = s_axis_cpl.DATA_W).
m_axis_cpl  taxi_axis_if.src  -  completions to host. tid = request ID (ID_W = REQ_W). tdata = timestamp.
stat_inflight  output  TAG_W+1  number of allocated tags.
stat_err_unk_tag  output  1  one-cycle pulse: a completion arrived for an unallocated tag.
stat_alloc_stall  output  1  high while a frame start is blocked because no tag is free.

Behaviour:
- Reset (asynchronous, active-high):
  - Free bitmap set to all-free; stat_inflight = 0.
  - Frame-active flag cleared; m_axis_cpl.tvalid = 0.
  - stat_err_unk_tag = 0; stat_alloc_stall = 0.
  - Request-ID table is not reset.
- TX data path:
  - Combinational pass-through of tdata/tkeep/tlast/tuser/tvalid/tready; zero added latency.
  - Only tid is replaced, with the current tag.
- Frame start (frame-active = 0):
  - If no tag is free: s_axis_tx.tready = 0 and m_axis_tx.tvalid = 0; stat_alloc_stall = s_axis_tx.tvalid.
  - If a tag is free: the selected tag is the lowest-index free tag, driven on m_axis_tx.tid.
  - On the handshake of the first beat: tag marked allocated, table[tag] <= s_axis_tx.tid, tag latched as current tag.
  - Frame-active set unless tlast is also set in that beat (single-beat frame).
- Mid-frame (frame-active = 1):
  - No tag check; the latched tag is driven on tid.
  - The request ID on later beats is ignored.
  - Frame-active clears on the tlast handshake.
- Bad frames (tuser = 1) still consume a tag. The downstream FIFO may drop such a frame; that tag is only freed by a completion.
- Completion path: one output register, 1-cycle latency.
  - s_axis_cpl.tready = !m_axis_cpl.tvalid || m_axis_cpl.tready (full throughput).
  - On handshake with the tag allocated: m_axis_cpl.tdata <= tdata, m_axis_cpl.tid <= table[tag], tvalid <= 1, tag freed.
  - On handshake with the tag not allocated: completion dropped, no output beat, stat_err_unk_tag pulses 1 on the next cycle, bitmap unchanged.
  - m_axis_cpl.tlast = 1 always; tkeep = all ones.
- stat_inflight counter:
  - +1 on allocation; -1 on valid free; unchanged when both occur in the same cycle.
  - Never exceeds 2**TAG_W.
- Simultaneous allocation and free:
  - Both are applied in the same cycle.
  - A tag freed in cycle N becomes allocatable from cycle N+1; the allocator sees the registered bitmap.
- Free and allocate of the same tag in one cycle is impossible, since allocation only selects free tags.
- Wrap-around: tags are reused indefinitely. Completions may return in any order; each is matched by tag only.
- Reset mid-frame: the frame-active flag and all tags are lost. Downstream must be reset together with this block.

Test Plan:
- Reset, then send a 3-beat frame with tid=0x5A -> m_axis_tx.tid = 0 on all beats; stat_inflight = 1. Completion tag 0, ts=0x1234 -> one cycle later m_axis_cpl tid=0x5A, tdata=0x1234; stat_inflight = 0.
- TAG_W=2: send 4 single-beat frames with IDs 1..4 -> tags 0,1,2,3 assigned. 5th frame: tready=0 and stat_alloc_stall=1 until completion tag 2 arrives; 5th frame then gets tag 2 one cycle later.
- Completions for tags 3,0,1 out of order -> outputs carry IDs 4,1,2 in that order with matching timestamps.
- Completion for never-allocated tag 7 -> no m_axis_cpl beat; stat_err_unk_tag high for exactly 1 cycle; stat_inflight unchanged.
- m_axis_cpl.tready held 0 with 2 completions queued -> first output held stable; s_axis_cpl.tready = 0 until drain; no loss or duplication.
- Same-cycle frame start and valid completion with inflight=2 -> stat_inflight stays 2; the freed tag is not assigned to the frame starting in that same cycle.
